// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch front end (ifu_pc).
//   ifu_state_e : fetch FSM state encoding (IDLE, RUN, HALTED)
//   PC_STEP     : sequential PC increment in bytes
//   NOP_INSTR   : value the fetch buffer holds out of reset
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } ifu_state_e;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch_buf.sv
// One-entry fetch buffer presenting an instruction and its PC to decode over valid/ready.
//   clk, rst_n           : clock, async active-low reset
//   load                 : capture load_instr/load_pc, mark valid
//   load_instr, load_pc  : incoming instruction word and its PC
//   flush                : drop the entry (wins over load and pop)
//   out_ready            : decode accepts the entry this cycle
//   out_valid            : entry present
//   out_instr, out_pc    : buffered instruction and PC
module ifu_fetch_buf
    import ifu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/ifu_pc.sv
// Instruction-fetch front end: owns the PC, addresses im_1k, buffers the fetched word
// with its PC for decode, and applies redirects and halt requests.
//   clk, rst_n               : clock, async active-low reset
//   im_addr / im_dout        : instruction memory byte address / returned word
//   redir_valid, redir_pc    : redirect request and target
//   halt                     : level-sensitive stop-fetch request
//   out_valid/out_ready      : handshake to decode; out_instr/out_pc carry the entry
//   pc                       : current fetch PC
// Build option IFU_ALIGN_CHECK_EN: adds sticky output fetch_err; a misaligned redirect
// target halts fetch and leaves pc unchanged. Without it, target bits [1:0] are cleared.
module ifu_pc
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    input  logic             redir_valid,
    input  logic [31:0]      redir_pc,
    input  logic             halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
`ifdef IFU_ALIGN_CHECK_EN
    output logic             fetch_err,
`endif
    output logic [31:0]      pc
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        buf_load;
    logic        buf_flush;
    logic        cap;
    logic        redir_bad;
    logic [31:0] redir_tgt;

`ifdef IFU_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign redir_tgt = redir_pc;
    assign redir_bad = |redir_pc[1:0];
`else
    assign redir_tgt = redir_pc & ~32'h3;
    assign redir_bad = 1'b0;
`endif

    // Buffer can take a new word when empty or being drained this cycle.
    assign cap = !out_valid || out_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (redir_valid) begin
                    // Redirect beats capture and kills any unaccepted entry.
                    buf_flush = 1'b1;
                    if (redir_bad) begin
`ifdef IFU_ALIGN_CHECK_EN
                        err_d = 1'b1;
`endif
                        state_d = HALTED;
                    end else begin
                        pc_d = redir_tgt;
                        if (halt) begin
                            state_d = HALTED;
                        end
                    end
                end else if (halt) begin
                    // Stay in RUN until the pending entry has been handed off.
                    if (cap) begin
                        state_d = HALTED;
                    end
                end else if (cap) begin
                    buf_load = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                end
            end
            HALTED: begin
                if (redir_valid && !halt) begin
                    buf_flush = 1'b1;
                    if (redir_bad) begin
`ifdef IFU_ALIGN_CHECK_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        pc_d    = redir_tgt;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`endif

    ifu_fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .load_instr (im_dout),
        .load_pc    (pc_q),
        .flush      (buf_flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
    );

    assign pc      = pc_q;
    assign im_addr = pc_q[IM_AW-1:0];

endmodule

// File: tb/tb_ifu_pc.sv
module tb_ifu_pc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        halt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] pc;
`ifdef IFU_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    assign im_dout = mem[im_addr[9:2]];

    ifu_pc #(
        .RESET_PC (32'h0000_0000),
        .IM_AW    (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .im_addr     (im_addr),
        .im_dout     (im_dout),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
`ifdef IFU_ALIGN_CHECK_EN
        .fetch_err   (fetch_err),
`endif
        .pc          (pc)
    );

    function automatic logic [31:0] word(input int k);
        return 32'h0001_0203 + 32'(k) * 32'h0404_0404;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word(i);

        // Reset values
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_outpc", out_pc, 32'h0);
        chk("rst_imaddr", {22'h0, im_addr}, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
`endif
        rst_n = 1'b1;

        // IDLE cycle: no capture
        step();
        chk("idle_valid", {31'h0, out_valid}, 32'h0);
        chk("idle_pc", pc, 32'h0);

        // Sequential fetch, ten words
        step();
        chk("seq0_valid", {31'h0, out_valid}, 32'h1);
        chk("seq0_instr", out_instr, 32'h0001_0203);
        chk("seq0_outpc", out_pc, 32'h0);
        chk("seq0_pc", pc, 32'h4);
        step();
        chk("seq1_instr", out_instr, 32'h0405_0607);
        chk("seq1_outpc", out_pc, 32'h4);
        for (int k = 2; k < 10; k++) begin
            step();
            chk("seq_valid", {31'h0, out_valid}, 32'h1);
            chk("seq_outpc", out_pc, 32'(4 * k));
            chk("seq_instr", out_instr, word(k));
        end
        chk("seq_end_pc", pc, 32'h28);

        // Redirect back to 0 with an accepted buffer
        redir_valid = 1'b1; redir_pc = 32'h0;
        step();
        chk("r0_valid", {31'h0, out_valid}, 32'h0);
        chk("r0_pc", pc, 32'h0);
        redir_valid = 1'b0;
        step();
        chk("r0_first", out_pc, 32'h0);
        step();
        step();
        chk("pre_stall_outpc", out_pc, 32'h8);
        chk("pre_stall_pc", pc, 32'hC);

        // Stall for three cycles
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_outpc", out_pc, 32'h8);
            chk("stall_instr", out_instr, 32'h0809_0A0B);
            chk("stall_pc", pc, 32'hC);
            chk("stall_imaddr", {22'h0, im_addr}, 32'hC);
        end
        out_ready = 1'b1;
        step();
        chk("resume_outpc", out_pc, 32'hC);
        chk("resume_instr", out_instr, 32'h0C0D_0E0F);
        step();
        chk("buf10_outpc", out_pc, 32'h10);
        chk("buf10_pc", pc, 32'h14);

        // Redirect while the buffer holds unaccepted pc=0x10
        out_ready = 1'b0;
        redir_valid = 1'b1; redir_pc = 32'h20;
        step();
        chk("redir_flush", {31'h0, out_valid}, 32'h0);
        chk("redir_pc", pc, 32'h20);
        redir_valid = 1'b0;
        step();
        chk("redir_cap_valid", {31'h0, out_valid}, 32'h1);
        chk("redir_cap_outpc", out_pc, 32'h20);
        chk("redir_cap_instr", out_instr, 32'h2021_2223);
        chk("redir_cap_pc", pc, 32'h24);

        // Halt with a pending, unaccepted entry
        halt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halt_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("halt_hold_outpc", out_pc, 32'h20);
            chk("halt_hold_pc", pc, 32'h24);
        end
        out_ready = 1'b1;
        step();
        chk("halt_accept", {31'h0, out_valid}, 32'h0);
        chk("halt_accept_pc", pc, 32'h24);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("halted_valid", {31'h0, out_valid}, 32'h0);
            chk("halted_pc", pc, 32'h24);
        end
        halt = 1'b0;
        step();
        chk("halted_nohalt_pc", pc, 32'h24);
        redir_valid = 1'b1; redir_pc = 32'h0;
        step();
        chk("unhalt_pc", pc, 32'h0);
        chk("unhalt_valid", {31'h0, out_valid}, 32'h0);
        redir_valid = 1'b0;
        step();
        chk("unhalt_cap_valid", {31'h0, out_valid}, 32'h1);
        chk("unhalt_cap_outpc", out_pc, 32'h0);
        chk("unhalt_cap_pc", pc, 32'h4);

        // im_addr wrap at IM_AW=10
        redir_valid = 1'b1; redir_pc = 32'h3FC;
        step();
        chk("wrap_pc", pc, 32'h3FC);
        chk("wrap_imaddr0", {22'h0, im_addr}, 32'h3FC);
        redir_valid = 1'b0;
        step();
        chk("wrap_outpc", out_pc, 32'h3FC);
        chk("wrap_instr", out_instr, word(255));
        chk("wrap_pc2", pc, 32'h400);
        chk("wrap_imaddr", {22'h0, im_addr}, 32'h0);
        step();
        chk("wrap_outpc2", out_pc, 32'h400);
        chk("wrap_instr2", out_instr, 32'h0001_0203);

        // 32-bit PC wrap
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
        step();
        chk("pcwrap_pc", pc, 32'hFFFF_FFFC);
        redir_valid = 1'b0;
        step();
        chk("pcwrap_outpc", out_pc, 32'hFFFF_FFFC);
        chk("pcwrap_next", pc, 32'h0);

        // Redirect together with halt: apply target, then stay halted
        halt = 1'b1;
        redir_valid = 1'b1; redir_pc = 32'h40;
        step();
        chk("hr_pc", pc, 32'h40);
        chk("hr_valid", {31'h0, out_valid}, 32'h0);
        halt = 1'b0;
        redir_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hr_halted_pc", pc, 32'h40);
            chk("hr_halted_valid", {31'h0, out_valid}, 32'h0);
        end

        // Misaligned redirect target
        redir_valid = 1'b1; redir_pc = 32'h22;
        step();
        redir_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        chk("mis_err", {31'h0, fetch_err}, 32'h1);
        chk("mis_pc", pc, 32'h40);
        step();
        chk("mis_err_sticky", {31'h0, fetch_err}, 32'h1);
        chk("mis_halted_valid", {31'h0, out_valid}, 32'h0);
        chk("mis_halted_pc", pc, 32'h40);
`else
        chk("mis_pc", pc, 32'h20);
        step();
        chk("mis_cap_outpc", out_pc, 32'h20);
        chk("mis_cap_instr", out_instr, 32'h2021_2223);
        chk("mis_cap_valid", {31'h0, out_valid}, 32'h1);
`endif

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'h0, out_valid}, 32'h0);
        chk("async_pc", pc, 32'h0);
        chk("async_instr", out_instr, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
        chk("async_err", {31'h0, fetch_err}, 32'h0);
`endif
        step();
        rst_n = 1'b1;
        step();
        chk("rerst_idle", {31'h0, out_valid}, 32'h0);
        step();
        chk("rerst_valid", {31'h0, out_valid}, 32'h1);
        chk("rerst_outpc", out_pc, 32'h0);
        chk("rerst_instr", out_instr, 32'h0001_0203);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_pc.md
Name: ifu_pc

Overview:
- Instruction-fetch front end sitting directly upstream of im_1k.
- Owns the program counter and drives the instruction memory byte address.
- Registers the returned instruction word together with its PC into a one-entry fetch buffer, which it presents to decode over a valid/ready handshake.
- Applies branch/jump redirects and a halt request from downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IM_AW, 10, byte-address width of the instruction memory (im_1k: 10).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- im_addr  out  IM_AW  byte address to im_1k; equals pc[IM_AW-1:0].
- im_dout  in  32  instruction word from im_1k, combinational from im_addr.
- redir_valid  in  1  redirect request (taken branch, j, jal, jr).
- redir_pc  in  32  redirect target.
- halt  in  1  stop fetching; level-sensitive.
- out_valid  out  1  fetch buffer holds an instruction.
- out_ready  in  1  decode accepts the buffer this cycle.
- out_instr  out  32  buffered instruction.
- out_pc  out  32  PC of the buffered instruction.
- pc  out  32  current fetch PC.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
  - State=IDLE.
- States:
  - IDLE: one cycle after reset release, no capture. Goes to RUN on the next clk edge.
  - RUN: normal fetch.
  - HALTED: no fetch. pc and buffer hold. Leaves only via reset, or redir_valid while halt=0, which goes to RUN.
- RUN, capture condition: cap = !out_valid | out_ready.
  - If cap and !redir_valid:
    - out_instr<=im_dout, out_pc<=pc, out_valid<=1.
    - pc<=pc+4, 32-bit wrap, so 32'hFFFF_FFFC -> 0.
  - If !cap (stall): pc, out_instr, out_pc and out_valid all hold. im_addr remains stable.
- Redirect has priority over capture:
  - pc<=redir_pc.
  - out_valid<=0 if out_ready, or if the buffer was empty. A buffered instruction not yet accepted is flushed (out_valid<=0) regardless of out_ready.
  - No instruction is captured that cycle.
  - Redirect-to-first-capture latency = 1 cycle.
- Halt:
  - halt=1 in RUN: no new capture, pc holds.
  - An existing valid buffer stays until accepted (out_valid drops after the out_ready handshake).
  - Then state -> HALTED.
  - halt together with redir_valid: redirect is applied to pc, then HALTED.
- Throughput: 1 instruction/cycle with out_ready held at 1.
- im_addr truncation: PC bits above IM_AW-1 are ignored, so the address wraps modulo 2^IM_AW.
- Reset asserted mid-operation: all state is cleared immediately and asynchronously. Any in-flight redirect is lost.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- When defined:
  - Adds output fetch_err (1 bit, reset 0).
  - A redirect with redir_pc[1:0]!=0 sets fetch_err=1 (sticky until reset), goes to HALTED, and leaves pc unchanged.
- When undefined:
  - No port is added.
  - redir_pc[1:0] is forced to 0 when loaded.

Decomposition:
- Shared package ifu_pkg:
  - State enum (IDLE, RUN, HALTED).
  - Constants PC_STEP=4 and NOP_INSTR=32'h0000_0000.
- One natural sub-module: ifu_fetch_buf, the one-entry valid/ready buffer holding instr and pc, with flush input.
- The PC register and FSM stay in the top.

Test Plan:
- Sequential fetch:
  - Stimulus: im_1k loaded with words 00010203 + k*04040404, out_ready=1, RESET_PC=0.
  - Required response: first valid cycle after IDLE gives out_instr=00010203, out_pc=0; then 04050607 at pc 4. Ten consecutive words, one per cycle.
- Stall:
  - Stimulus: drop out_ready for 3 cycles while out_valid=1 with out_pc=8.
  - Required response: out_instr, out_pc=8, pc=C and im_addr=C stable for all 3 cycles. Resume with out_pc=C next.
- Redirect:
  - Stimulus: redir_valid=1, redir_pc=0x20 while the buffer holds unaccepted pc=0x10.
  - Required response: next cycle out_valid=0, pc=0x20; the following cycle out_pc=0x20, out_instr=20212223.
- Halt:
  - Stimulus: assert halt with the buffer valid and out_ready=0 for 2 cycles, then out_ready=1.
  - Required response: buffer accepted once; out_valid=0 and pc frozen afterwards. Redirect to 0 with halt=0 resumes fetching at 0.
- Wrap/reset:
  - Stimulus: redirect to 0x3FC with IM_AW=10.
  - Required response: next im_addr=0x000 while pc=0x400.
  - Stimulus: assert rst_n=0 mid-stream.
  - Required response: out_valid=0 and pc=0 immediately, without waiting for a clk edge.
- With IFU_ALIGN_CHECK_EN:
  - Stimulus: redir_pc=0x22.
  - Required response: fetch_err=1, state HALTED, pc unchanged.
